// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for param_stack.
//   op_t        - decoded per-cycle operation from {pop, push}
//   count_width - bits needed to hold an occupancy of 0..depth inclusive
package stack_pkg;

  // Encoding matches {pop, push} so the decode is a plain cast.
  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_mem.sv
// stack_mem: storage array for param_stack.
// One synchronous write port, one asynchronous read port. The array is
// deliberately not reset; occupancy tracking in the parent decides which
// entries are meaningful.
// Ports:
//   clk      in  clock
//   i_we     in  write enable
//   i_waddr  in  write address
//   i_wdata  in  write data
//   i_raddr  in  read address
//   o_rdata  out read data (combinational from i_raddr)
module stack_mem #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous read: the same word feeds both the top-of-stack peek and
  // the pop-data register in the parent.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO stack with replace-top, synchronous clear,
// pop-data valid strobe and one-cycle overflow/underflow pulses.
// Ports:
//   clk        in   clock, all state changes on rising edge
//   rst        in   synchronous active-high reset
//   clear      in   synchronous flush (count -> 0), push/pop ignored
//   push       in   write data_in onto the stack
//   pop        in   remove top entry into data_out
//   data_in    in   word to push
//   data_out   out  registered popped word, held until next successful pop
//   out_valid  out  pulse: data_out updated by the last edge
//   top        out  combinational peek of current top entry, 0 when empty
//   count      out  occupancy 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//   overflow   out  pulse: a push was dropped
//   underflow  out  pulse: a pop was dropped
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256,
  localparam int CW   = count_width(DEPTH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_out_valid;
  logic             r_overflow;
  logic             r_underflow;

  op_t              w_op;
  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_rd_addr;
  logic [AW-1:0]    w_wr_addr;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_we;

  assign w_op    = op_t'({pop, push});
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Address of the current top entry. Wraps when empty, but every consumer
  // of the read data is gated by w_empty, so that value is never used.
  assign w_rd_addr = AW'(r_count - CW'(1));

  // Replace-top writes over the current top; every other accepted push
  // (including push+pop on an empty stack) writes the next free slot.
  assign w_wr_addr = (pop && !w_empty) ? w_rd_addr : AW'(r_count);

  // A push is accepted unless the stack is full with no accompanying pop.
  // Reset and clear both suppress the write.
  assign w_we = !rst && !clear && push && (pop || !w_full);

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wr_addr),
    .i_wdata (data_in),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      // data_out is intentionally held across a flush.
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      case (w_op)
        OP_PUSH: begin
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        OP_POP: begin
          if (w_empty) begin
            r_underflow <= 1'b1;
          end else begin
            r_data_out  <= w_rd_data;
            r_out_valid <= 1'b1;
            r_count     <= r_count - CW'(1);
          end
        end
        OP_REPLACE: begin
          if (w_empty) begin
            // The push half lands in slot 0; only the pop half is dropped.
            r_count     <= CW'(1);
            r_underflow <= 1'b1;
          end else begin
            // Occupancy unchanged, so a full stack cannot overflow here.
            r_data_out  <= w_rd_data;
            r_out_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign top       = w_empty ? '0 : w_rd_data;

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: scoreboard bench for param_stack (WIDTH=8, DEPTH=4).
// The driver applies one operation per cycle, advances a queue-based
// reference stack and pushes the expected visible state into exp_q.
// A monitor on the falling edge pops one entry per cycle and compares.
module tb_param_stack;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic [W-1:0] top;
  logic [2:0]   count;
  logic         empty;
  logic         full;
  logic         overflow;
  logic         underflow;

  always #5 clk = ~clk;

  param_stack #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct packed {
    logic [7:0] dout;
    logic       valid;
    logic [2:0] cnt;
    logic [7:0] tp;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Reference model: the stack is a queue, back = top.
  logic [7:0] stk[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  task automatic model_step(input logic r, input logic c, input logic pu,
                            input logic po, input logic [7:0] d);
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    if (r) begin
      stk.delete();
      m_dout = 8'h00;
    end else if (c) begin
      stk.delete();
    end else if (pu && po) begin
      if (stk.size() > 0) begin
        m_dout = stk[stk.size()-1];
        stk[stk.size()-1] = d;
        m_valid = 1'b1;
      end else begin
        stk.push_back(d);
        m_udf = 1'b1;
      end
    end else if (pu) begin
      if (stk.size() < D) stk.push_back(d);
      else m_ovf = 1'b1;
    end else if (po) begin
      if (stk.size() > 0) begin
        m_dout  = stk.pop_back();
        m_valid = 1'b1;
      end else begin
        m_udf = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic pu,
                       input logic po, input logic [7:0] d);
    exp_t e;
    rst = r; clear = c; push = pu; pop = po; data_in = d;
    @(posedge clk);
    #1;
    model_step(r, c, pu, po, d);
    e.dout  = m_dout;
    e.valid = m_valid;
    e.cnt   = 3'(stk.size());
    e.tp    = (stk.size() > 0) ? stk[stk.size()-1] : 8'h00;
    e.emp   = (stk.size() == 0);
    e.ful   = (stk.size() == D);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    exp_q.push_back(e);
    $display("txn %0d rst=%0b clr=%0b push=%0b pop=%0b din=%02h -> cnt=%0d top=%02h dout=%02h",
             txn, r, c, pu, po, d, e.cnt, e.tp, e.dout);
    txn++;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %02h expected %02h", nm, $time, act, expv);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data_out",  data_out,          e.dout);
      chk("out_valid", {7'd0, out_valid}, {7'd0, e.valid});
      chk("count",     {5'd0, count},     {5'd0, e.cnt});
      chk("top",       top,               e.tp);
      chk("empty",     {7'd0, empty},     {7'd0, e.emp});
      chk("full",      {7'd0, full},      {7'd0, e.ful});
      chk("overflow",  {7'd0, overflow},  {7'd0, e.ovf});
      chk("underflow", {7'd0, underflow}, {7'd0, e.udf});
    end
  end

  initial begin
    logic r, c, pu, po;
    // Reset, then idle.
    drive(1, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    // Fill, then overflow.
    drive(0, 0, 1, 0, 8'h11);
    drive(0, 0, 1, 0, 8'h22);
    drive(0, 0, 1, 0, 8'h33);
    drive(0, 0, 1, 0, 8'h44);
    drive(0, 0, 1, 0, 8'h55);
    // Drain, then underflow.
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 8'h00);
    // Replace-top on partially filled and on full stack.
    drive(0, 0, 1, 0, 8'hA0);
    drive(0, 0, 1, 0, 8'hB0);
    drive(0, 0, 1, 1, 8'hC0);
    drive(0, 0, 1, 0, 8'h01);
    drive(0, 0, 1, 0, 8'h02);
    drive(0, 0, 1, 1, 8'hD0);
    drive(0, 0, 0, 0, 8'h00);
    // Replace on empty.
    drive(0, 1, 0, 0, 8'h00);
    drive(0, 0, 1, 1, 8'h5A);
    // Clear wins over push.
    drive(0, 0, 1, 0, 8'h61);
    drive(0, 0, 1, 0, 8'h62);
    drive(0, 1, 1, 0, 8'h63);
    drive(0, 0, 0, 0, 8'h00);
    // Reset wins over pop.
    drive(0, 0, 1, 0, 8'h71);
    drive(0, 0, 1, 0, 8'h72);
    drive(0, 0, 1, 0, 8'h73);
    drive(1, 0, 0, 1, 8'h00);
    drive(0, 0, 0, 1, 8'h00);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(99) == 0);
      c  = ($urandom_range(39) == 0);
      pu = ($urandom_range(99) < 55);
      po = ($urandom_range(99) < 45);
      drive(r, c, pu, po, 8'($urandom));
    end
    drive(0, 0, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
